// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS core: ID decode, ID/EX-EX/MEM-MEM/WB
// control registers, load-use and branch hazard stalls, EX and ID-comparator forwarding.
module pipe_ctrl_unit #(
  parameter int ALUOP_W    = 3,
  parameter int REG_W      = 5,
  parameter int LINK_REG   = 31,
  parameter int ENABLE_IMM = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               equal,
  input  logic               bubble_in,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic [1:0]         PCsrc,
  output logic               id_fwd_a,
  output logic               id_fwd_b,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_imm_zext,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg,
  output logic               wb_link,
  output logic [REG_W-1:0]   wb_dst
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_NOP = '1;

  localparam logic [REG_W-1:0] LINK_DST = REG_W'(LINK_REG);

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               link;
    logic               alu_src;
    logic               imm_zext;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   dst;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
  } ex_ctrl_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             link;
    logic [REG_W-1:0] dst;
  } mem_ctrl_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             link;
    logic [REG_W-1:0] dst;
  } wb_ctrl_t;

  function automatic ex_ctrl_t ex_bubble();
    ex_ctrl_t c;
    c        = '0;
    c.alu_op = ALU_NOP;
    return c;
  endfunction

  // Register 0 is hard-wired, so it never creates a dependence.
  function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src,
                               input logic used);
    return used && (src != '0) && (dst == src);
  endfunction

  ex_ctrl_t  idex;
  mem_ctrl_t exmem;
  wb_ctrl_t  memwb;

  ex_ctrl_t           dec;
  logic               known;
  logic               uses_rs;
  logic               uses_rt;
  logic               is_beq;
  logic               is_bne;
  logic               is_jump;
  logic               is_jr;
  logic               r_alu;
  logic [ALUOP_W-1:0] r_op;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    dec     = ex_bubble();
    known   = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jump = 1'b0;
    is_jr   = 1'b0;
    r_alu   = 1'b1;
    r_op    = ALU_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  r_op = ALU_ADD;
          FN_SUB:  r_op = ALU_SUB;
          FN_AND:  r_op = ALU_AND;
          FN_OR:   r_op = ALU_OR;
          FN_SLT:  r_op = ALU_SLT;
          FN_JR: begin
            r_alu   = 1'b0;
            known   = 1'b1;
            uses_rs = 1'b1;
            is_jr   = 1'b1;
          end
          default: r_alu = 1'b0;
        endcase
        if (r_alu) begin
          known         = 1'b1;
          uses_rs       = 1'b1;
          uses_rt       = 1'b1;
          dec.reg_write = 1'b1;
          dec.dst       = id_rd;
          dec.alu_op    = r_op;
        end
      end
      OP_LW: begin
        known          = 1'b1;
        uses_rs        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
        dec.dst        = id_rt;
      end
      OP_SW: begin
        known         = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_J: begin
        known   = 1'b1;
        is_jump = 1'b1;
      end
      OP_JAL: begin
        known         = 1'b1;
        is_jump       = 1'b1;
        dec.reg_write = 1'b1;
        dec.link      = 1'b1;
        dec.dst       = LINK_DST;
      end
      OP_BEQ, OP_BNE: begin
        known   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (ENABLE_IMM != 0) begin
          known         = 1'b1;
          uses_rs       = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.dst       = id_rt;
          dec.imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
          case (opcode)
            OP_ADDI: dec.alu_op = ALU_ADD;
            OP_ANDI: dec.alu_op = ALU_AND;
            OP_ORI:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_SLT;
          endcase
        end
      end
      default: known = 1'b0;
    endcase
    dec.rs = id_rs;
    dec.rt = id_rt;
  end

  logic load_use;
  logic branch_stall;
  logic stall;
  logic taken;

  assign load_use = idex.mem_read &&
                    (hit(idex.dst, id_rs, uses_rs) || hit(idex.dst, id_rt, uses_rt));

  // The ID comparator needs its operands at the start of ID: an ALU result still in
  // EX, or load data still in MEM, is not yet forwardable.
  assign branch_stall = (is_beq || is_bne || is_jr) &&
                        ((idex.reg_write &&
                          (hit(idex.dst, id_rs, uses_rs) || hit(idex.dst, id_rt, uses_rt))) ||
                         (exmem.mem_read &&
                          (hit(exmem.dst, id_rs, uses_rs) || hit(exmem.dst, id_rt, uses_rt))));

  assign stall = !bubble_in && (load_use || branch_stall);
  assign taken = (is_beq && equal) || (is_bne && !equal);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    PCsrc      = 2'd0;
    ifid_flush = 1'b0;
    if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (!bubble_in) begin
      if (taken) begin
        PCsrc      = 2'd1;
        ifid_flush = 1'b1;
      end else if (is_jump) begin
        PCsrc      = 2'd2;
        ifid_flush = 1'b1;
      end else if (is_jr) begin
        PCsrc      = 2'd3;
        ifid_flush = 1'b1;
      end
    end
  end

  // A load's data is not available at the EX/MEM ALU-result tap.
  assign id_fwd_a = exmem.reg_write && !exmem.mem_read && hit(exmem.dst, id_rs, 1'b1);
  assign id_fwd_b = exmem.reg_write && !exmem.mem_read && hit(exmem.dst, id_rt, 1'b1);

  assign fwd_a = hit(exmem.dst, idex.rs, exmem.reg_write) ? 2'b10 :
                 hit(memwb.dst, idex.rs, memwb.reg_write) ? 2'b01 : 2'b00;
  assign fwd_b = hit(exmem.dst, idex.rt, exmem.reg_write) ? 2'b10 :
                 hit(memwb.dst, idex.rt, memwb.reg_write) ? 2'b01 : 2'b00;

  // NOTE: state registers use non-blocking assignment so every stage samples the
  // previous stage's pre-edge value; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= ex_bubble();
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= (stall || bubble_in || !known) ? ex_bubble() : dec;
      exmem <= '{reg_write:  idex.reg_write,
                 mem_read:   idex.mem_read,
                 mem_write:  idex.mem_write,
                 mem_to_reg: idex.mem_to_reg,
                 link:       idex.link,
                 dst:        idex.dst};
      memwb <= '{reg_write:  exmem.reg_write,
                 mem_to_reg: exmem.mem_to_reg,
                 link:       exmem.link,
                 dst:        exmem.dst};
    end
  end

  assign ex_alu_op     = idex.alu_op;
  assign ex_alu_src    = idex.alu_src;
  assign ex_imm_zext   = idex.imm_zext;
  assign mem_mem_read  = exmem.mem_read;
  assign mem_mem_write = exmem.mem_write;
  assign wb_reg_write  = memwb.reg_write;
  assign wb_mem_to_reg = memwb.mem_to_reg;
  assign wb_link       = memwb.link;
  assign wb_dst        = memwb.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed hazard scenarios plus a random
// instruction stream, compared against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, func;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       equal, bubble_in;

  logic       pc_write, ifid_write, ifid_flush, id_fwd_a, id_fwd_b;
  logic [1:0] PCsrc, fwd_a, fwd_b;
  logic [2:0] ex_alu_op;
  logic       ex_alu_src, ex_imm_zext, mem_mem_read, mem_mem_write;
  logic       wb_reg_write, wb_mem_to_reg, wb_link;
  logic [4:0] wb_dst;

  logic       pc_write_0, ifid_write_0, ifid_flush_0, id_fwd_a_0, id_fwd_b_0;
  logic [1:0] PCsrc_0, fwd_a_0, fwd_b_0;
  logic [2:0] ex_alu_op_0;
  logic       ex_alu_src_0, ex_imm_zext_0, mem_mem_read_0, mem_mem_write_0;
  logic       wb_reg_write_0, wb_mem_to_reg_0, wb_link_0;
  logic [4:0] wb_dst_0;

  pipe_ctrl_unit #(.ALUOP_W(3), .REG_W(5), .LINK_REG(31), .ENABLE_IMM(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .equal(equal), .bubble_in(bubble_in),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .PCsrc(PCsrc),
    .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_imm_zext(ex_imm_zext), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_link(wb_link),
    .wb_dst(wb_dst)
  );

  pipe_ctrl_unit #(.ALUOP_W(3), .REG_W(5), .LINK_REG(31), .ENABLE_IMM(0)) dut_noimm (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .equal(equal), .bubble_in(bubble_in),
    .pc_write(pc_write_0), .ifid_write(ifid_write_0), .ifid_flush(ifid_flush_0),
    .PCsrc(PCsrc_0), .id_fwd_a(id_fwd_a_0), .id_fwd_b(id_fwd_b_0),
    .ex_alu_op(ex_alu_op_0), .ex_alu_src(ex_alu_src_0), .ex_imm_zext(ex_imm_zext_0),
    .fwd_a(fwd_a_0), .fwd_b(fwd_b_0), .mem_mem_read(mem_mem_read_0),
    .mem_mem_write(mem_mem_write_0), .wb_reg_write(wb_reg_write_0),
    .wb_mem_to_reg(wb_mem_to_reg_0), .wb_link(wb_link_0), .wb_dst(wb_dst_0)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_JR, K_LW, K_SW, K_J, K_JAL,
    K_BEQ, K_BNE, K_ADDI, K_ANDI, K_ORI, K_SLTI, K_NOP, K_BAD
  } kind_e;

  typedef struct {
    kind_e      kind;
    logic [4:0] rs, rt, rd;
  } instr_t;

  // One pipeline slot of the model; a bubble is K_NOP with all registers 0.
  typedef struct {
    kind_e      kind;
    logic [4:0] dst, rs, rt;
  } stage_t;

  typedef struct {
    bit       stall;
    bit [1:0] pcsrc;
    bit       flush;
    bit       ida, idb;
    bit [1:0] fa, fb;
  } exp_t;

  stage_t ex_s, mem_s, wb_s;
  int tests  = 0;
  int failed = 0;

  function automatic bit is_ralu(kind_e k);
    return k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
  endfunction
  function automatic bit is_imm(kind_e k);
    return k inside {K_ADDI, K_ANDI, K_ORI, K_SLTI};
  endfunction
  function automatic bit known(kind_e k);
    return !(k inside {K_NOP, K_BAD});
  endfunction
  function automatic bit writes(kind_e k);
    return is_ralu(k) || is_imm(k) || k == K_LW || k == K_JAL;
  endfunction
  function automatic bit uses_rs(kind_e k);
    return known(k) && !(k inside {K_J, K_JAL});
  endfunction
  function automatic bit uses_rt(kind_e k);
    return is_ralu(k) || (k inside {K_SW, K_BEQ, K_BNE});
  endfunction
  function automatic logic [4:0] dst_of(instr_t i);
    if (is_ralu(i.kind)) return i.rd;
    if (i.kind == K_LW || is_imm(i.kind)) return i.rt;
    if (i.kind == K_JAL) return 5'd31;
    return 5'd0;
  endfunction
  function automatic logic [2:0] alu_code(kind_e k);
    case (k)
      K_ADD, K_ADDI: return 3'd0;
      K_SUB:         return 3'd1;
      K_AND, K_ANDI: return 3'd2;
      K_OR,  K_ORI:  return 3'd3;
      K_SLT, K_SLTI: return 3'd4;
      default:       return 3'd7;
    endcase
  endfunction
  function automatic bit hit(logic [4:0] d, logic [4:0] s, bit used);
    return used && s != 5'd0 && d == s;
  endfunction

  function automatic instr_t mk(kind_e k, int rd, int rs, int rt);
    instr_t i;
    i.kind = k;
    i.rd = 5'(rd);
    i.rs = 5'(rs);
    i.rt = 5'(rt);
    return i;
  endfunction

  function automatic exp_t predict(instr_t i, bit eq, bit bub);
    exp_t e;
    bit lu, bs, a_ex, a_mem;
    e = '{default: 0};
    lu = ex_s.kind == K_LW &&
         (hit(ex_s.dst, i.rs, uses_rs(i.kind)) || hit(ex_s.dst, i.rt, uses_rt(i.kind)));
    a_ex  = hit(ex_s.dst, i.rs, uses_rs(i.kind)) || hit(ex_s.dst, i.rt, uses_rt(i.kind));
    a_mem = hit(mem_s.dst, i.rs, uses_rs(i.kind)) || hit(mem_s.dst, i.rt, uses_rt(i.kind));
    bs = (i.kind inside {K_BEQ, K_BNE, K_JR}) &&
         ((writes(ex_s.kind) && a_ex) || (mem_s.kind == K_LW && a_mem));
    e.stall = !bub && (lu || bs);
    if (!bub && !e.stall) begin
      if ((i.kind == K_BEQ && eq) || (i.kind == K_BNE && !eq)) e.pcsrc = 2'd1;
      else if (i.kind inside {K_J, K_JAL})                      e.pcsrc = 2'd2;
      else if (i.kind == K_JR)                                  e.pcsrc = 2'd3;
    end
    e.flush = (e.pcsrc != 2'd0);
    e.ida = writes(mem_s.kind) && mem_s.kind != K_LW && hit(mem_s.dst, i.rs, 1'b1);
    e.idb = writes(mem_s.kind) && mem_s.kind != K_LW && hit(mem_s.dst, i.rt, 1'b1);
    e.fa = hit(mem_s.dst, ex_s.rs, writes(mem_s.kind)) ? 2'b10 :
           hit(wb_s.dst, ex_s.rs, writes(wb_s.kind))   ? 2'b01 : 2'b00;
    e.fb = hit(mem_s.dst, ex_s.rt, writes(mem_s.kind)) ? 2'b10 :
           hit(wb_s.dst, ex_s.rt, writes(wb_s.kind))   ? 2'b01 : 2'b00;
    return e;
  endfunction

  task automatic model_reset();
    ex_s  = '{kind: K_NOP, dst: 5'd0, rs: 5'd0, rt: 5'd0};
    mem_s = ex_s;
    wb_s  = ex_s;
  endtask

  task automatic advance(instr_t i, bit kill);
    wb_s  = mem_s;
    mem_s = ex_s;
    if (kill || !known(i.kind)) ex_s = '{kind: K_NOP, dst: 5'd0, rs: 5'd0, rt: 5'd0};
    else ex_s = '{kind: i.kind, dst: dst_of(i), rs: i.rs, rt: i.rt};
  endtask

  task automatic drive(instr_t i, bit eq, bit bub);
    case (i.kind)
      K_ADD:  begin opcode = 6'b000000; func = 6'b100000; end
      K_SUB:  begin opcode = 6'b000000; func = 6'b100010; end
      K_AND:  begin opcode = 6'b000000; func = 6'b100100; end
      K_OR:   begin opcode = 6'b000000; func = 6'b100101; end
      K_SLT:  begin opcode = 6'b000000; func = 6'b101010; end
      K_JR:   begin opcode = 6'b000000; func = 6'b001000; end
      K_LW:   begin opcode = 6'b100011; func = 6'(i.rd); end
      K_SW:   begin opcode = 6'b101011; func = 6'(i.rd); end
      K_J:    begin opcode = 6'b000010; func = 6'(i.rd); end
      K_JAL:  begin opcode = 6'b000011; func = 6'(i.rd); end
      K_BEQ:  begin opcode = 6'b000100; func = 6'(i.rd); end
      K_BNE:  begin opcode = 6'b000101; func = 6'(i.rd); end
      K_ADDI: begin opcode = 6'b001000; func = 6'(i.rd); end
      K_ANDI: begin opcode = 6'b001100; func = 6'(i.rd); end
      K_ORI:  begin opcode = 6'b001101; func = 6'(i.rd); end
      K_SLTI: begin opcode = 6'b001010; func = 6'(i.rd); end
      K_BAD:  begin opcode = 6'b111111; func = 6'b100000; end
      default: begin opcode = 6'b000000; func = 6'b000000; end
    endcase
    id_rs = i.rs;
    id_rt = i.rt;
    id_rd = i.rd;
    equal = eq;
    bubble_in = bub;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(exp_t e);
    check("pc_write", pc_write, !e.stall);
    check("ifid_write", ifid_write, !e.stall);
    check("PCsrc", PCsrc, e.pcsrc);
    check("ifid_flush", ifid_flush, e.flush);
    check("id_fwd_a", id_fwd_a, e.ida);
    check("id_fwd_b", id_fwd_b, e.idb);
    check("fwd_a", fwd_a, e.fa);
    check("fwd_b", fwd_b, e.fb);
    if (is_ralu(ex_s.kind) || is_imm(ex_s.kind) || ex_s.kind inside {K_NOP, K_JAL})
      check("ex_alu_op", ex_alu_op, alu_code(ex_s.kind));
    if (is_ralu(ex_s.kind) || is_imm(ex_s.kind) || ex_s.kind == K_NOP)
      check("ex_alu_src", ex_alu_src, is_imm(ex_s.kind));
    check("ex_imm_zext", ex_imm_zext, ex_s.kind inside {K_ANDI, K_ORI});
    check("mem_mem_read", mem_mem_read, mem_s.kind == K_LW);
    check("mem_mem_write", mem_mem_write, mem_s.kind == K_SW);
    check("wb_reg_write", wb_reg_write, writes(wb_s.kind));
    check("wb_mem_to_reg", wb_mem_to_reg, wb_s.kind == K_LW);
    check("wb_link", wb_link, wb_s.kind == K_JAL);
    check("wb_dst", wb_dst, wb_s.dst);
  endtask

  // Presents one instruction in ID, holding it while the model says it is stalled.
  task automatic issue(input instr_t ins, input bit eq, input bit bub,
                       output int n_stall, output logic [1:0] o_pcs, output logic o_fl,
                       output logic o_ida, output bit m_fl);
    exp_t e;
    bit done;
    done = 0;
    n_stall = 0;
    for (int cyc = 0; cyc < 5 && !done; cyc++) begin
      drive(ins, eq, bub);
      #1;
      e = predict(ins, eq, bub);
      check_all(e);
      if (pc_write === 1'b0) n_stall++;
      o_pcs = PCsrc;
      o_fl  = ifid_flush;
      o_ida = id_fwd_a;
      m_fl  = e.flush;
      @(posedge clk);
      advance(ins, e.stall || bub);
      #1;
      done = !e.stall;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive(mk(K_NOP, 0, 0, 0), 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ns;
    logic [1:0] pcs;
    logic fl, ida;
    bit mfl, flushed;
    instr_t cur;
    exp_t e;

    reset_dut();
    #1;
    check("rst_pc_write", pc_write, 1'b1);
    check("rst_ex_alu_op", ex_alu_op, 3'b111);
    check("rst_wb_reg_write", wb_reg_write, 1'b0);
    check("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
    check_all(predict(mk(K_NOP, 0, 0, 0), 1'b0, 1'b0));

    // EX forwarding from MEM, then from WB across one independent instruction
    issue(mk(K_ADD, 3, 1, 2), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_SUB, 4, 3, 1), 0, 0, ns, pcs, fl, ida, mfl);
    check("fwd_mem_sub", fwd_a, 2'b10);
    issue(mk(K_ADD, 3, 1, 2), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_OR, 9, 1, 2), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_SUB, 4, 3, 1), 0, 0, ns, pcs, fl, ida, mfl);
    check("fwd_wb_sub", fwd_a, 2'b01);

    // Load-use: one stall, then forwarding from WB
    issue(mk(K_LW, 0, 1, 5), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_ADD, 6, 5, 2), 0, 0, ns, pcs, fl, ida, mfl);
    check("lw_use_stalls", ns, 1);
    check("lw_use_fwd", fwd_a, 2'b01);

    // Load followed by a branch on the loaded register: two stalls
    issue(mk(K_LW, 0, 1, 5), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_BEQ, 0, 5, 0), 1, 0, ns, pcs, fl, ida, mfl);
    check("lw_beq_stalls", ns, 2);
    check("lw_beq_pcsrc", pcs, 2'd1);
    check("lw_beq_flush", fl, 1'b1);

    // ALU result then branch: one stall, then comparator forwarding
    issue(mk(K_ADD, 7, 1, 2), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_BEQ, 0, 7, 2), 1, 0, ns, pcs, fl, ida, mfl);
    check("add_beq_stalls", ns, 1);
    check("add_beq_idfwd", ida, 1'b1);
    check("add_beq_pcsrc", pcs, 2'd1);

    // jal redirects and writes the link register three cycles later
    issue(mk(K_JAL, 0, 0, 0), 0, 0, ns, pcs, fl, ida, mfl);
    check("jal_pcsrc", pcs, 2'd2);
    check("jal_flush", fl, 1'b1);
    issue(mk(K_NOP, 0, 0, 0), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_NOP, 0, 0, 0), 0, 0, ns, pcs, fl, ida, mfl);
    check("jal_wb_write", wb_reg_write, 1'b1);
    check("jal_wb_link", wb_link, 1'b1);
    check("jal_wb_dst", wb_dst, 5'd31);

    // I-type decode, with and without immediate support
    issue(mk(K_ORI, 0, 1, 8), 0, 0, ns, pcs, fl, ida, mfl);
    check("ori_alu_op", ex_alu_op, 3'd3);
    check("ori_zext", ex_imm_zext, 1'b1);
    check("ori_alu_src", ex_alu_src, 1'b1);
    issue(mk(K_ADDI, 0, 1, 8), 0, 0, ns, pcs, fl, ida, mfl);
    check("noimm_addi_alu_op", ex_alu_op_0, 3'b111);
    check("noimm_addi_alu_src", ex_alu_src_0, 1'b0);
    issue(mk(K_NOP, 0, 0, 0), 0, 0, ns, pcs, fl, ida, mfl);
    issue(mk(K_NOP, 0, 0, 0), 0, 0, ns, pcs, fl, ida, mfl);
    check("noimm_addi_wb_write", wb_reg_write_0, 1'b0);
    check("imm_addi_wb_write", wb_reg_write, 1'b1);

    // bubble_in suppresses a taken branch
    issue(mk(K_BEQ, 0, 1, 2), 1, 1, ns, pcs, fl, ida, mfl);
    check("bubble_beq_pcsrc", pcs, 2'd0);
    check("bubble_beq_flush", fl, 1'b0);

    // Asynchronous reset in the middle of a load-use stall
    issue(mk(K_LW, 0, 1, 5), 0, 0, ns, pcs, fl, ida, mfl);
    cur = mk(K_ADD, 6, 5, 2);
    drive(cur, 1'b0, 1'b0);
    #1;
    e = predict(cur, 1'b0, 1'b0);
    check_all(e);
    check("pre_rst_stall", pc_write, 1'b0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_pc_write", pc_write, 1'b1);
    check("midrst_wb_write", wb_reg_write, 1'b0);
    check("midrst_fwd", {fwd_a, fwd_b}, 4'b0000);
    check("midrst_alu_op", ex_alu_op, 3'b111);
    e = predict(cur, 1'b0, 1'b0);
    check_all(e);
    #2 rst = 1'b0;
    @(posedge clk);
    advance(cur, e.stall);
    #1;

    // Random stream with a small register window to provoke hazards
    flushed = 0;
    for (int n = 0; n < 400; n++) begin
      if (flushed) cur = mk(K_NOP, 0, 0, 0);
      else cur = mk(kind_e'($urandom_range(0, 17)), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
      issue(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ns, pcs, fl, ida, mfl);
      flushed = mfl;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
